comp_edge_capture: RTL and testbench
====================================

Name: comp_edge_capture

Overview:
- Digital receiver for the on-chip comparator output (comparator vout, returned through a user GPIO input).
- Synchronizes and glitch-filters the asynchronous comparator bit, then counts rising and falling edges.
- Measures the rising-to-rising period in clock cycles.
- Exposes level, counts and period to the management SoC over a Wishbone slave, and raises a maskable interrupt on edges.

Parameters:
- FILT_LEN, 4: consecutive identical synchronized samples required before the filtered level changes. Range 1..15.
- CNT_W, 16: width of the edge counters. Range 8..32.
- PER_W, 24: width of the period counter and period register. Range 8..32.

Ports:
- wb_clk_i  input  1  sole clock for the block.
- wb_rst_ni  input  1  synchronous, active-low reset.
- comp_in  input  1  raw comparator output; asynchronous to wb_clk_i.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_we_i  input  1  Wishbone write enable.
- wbs_sel_i  input  4  byte selects; writes honour byte lanes.
- wbs_adr_i  input  32  address; only bits [4:2] are decoded.
- wbs_dat_i  input  32  write data.
- wbs_ack_o  output  1  Wishbone acknowledge.
- wbs_dat_o  output  32  read data.
- irq_o  output  1  level interrupt.
- comp_level_o  output  1  filtered comparator level.

Behaviour:
- Reset: wb_rst_ni low at a clock edge clears all state.
  - Outputs: wbs_ack_o=0, wbs_dat_o=0, irq_o=0, comp_level_o=0.
  - Internal state: sync flops 0, counters 0, CTRL 0, STATUS 0.
  - Reset mid-transaction drops ack; the bus master retries.
- Synchronizer: 2-flop chain on comp_in. Always runs, including when disabled.
- Filter (active only when CTRL.en=1):
  - fcnt increments each cycle the synced bit differs from comp_level_o.
  - fcnt resets to 0 on any cycle where they match.
  - When fcnt reaches FILT_LEN-1 and the bit still differs, comp_level_o toggles next edge and fcnt returns to 0.
  - Latency from a clean input step to the comp_level_o change is 2+FILT_LEN cycles.
  - Pulses shorter than FILT_LEN samples never propagate.
- Enable transition: on the cycle CTRL.en goes 0->1, comp_level_o loads the synced bit directly with no edge generated. While en=0, comp_level_o holds and no edges or counting occur.
- Edge events: rise/fall are single-cycle pulses coincident with the comp_level_o toggle.
  - RISE_CNT/FALL_CNT increment on their event and saturate at all-ones (no wrap).
- Period measurement:
  - per_cnt is idle at 0 until the first rise after enable or clear.
  - That first rise sets per_cnt=1 and sets STATUS.armed.
  - per_cnt then increments each cycle, saturating at all-ones.
  - On each later rise: PERIOD<=per_cnt, per_cnt<=1, STATUS.per_valid<=1.
  - PERIOD therefore equals the exact cycle distance between the rising-edge pulses.
- Register map (word offset from wbs_adr_i[4:2]):
  - 0 CTRL (RW): [0] en, [1] rise_ie, [2] fall_ie, [3] clr. clr is write-only, self-clearing, and reads 0.
  - 1 STATUS: [0] level (RO), [1] rise_pend (W1C), [2] fall_pend (W1C), [3] armed (RO), [4] per_valid (RO).
  - 2 RISE_CNT (RO).
  - 3 FALL_CNT (RO).
  - 4 PERIOD (RO).
  - 5..7 read 0; writes to them are ignored. Unused high bits read 0.
- clr effect: clears RISE_CNT, FALL_CNT, PERIOD, per_cnt, armed and per_valid in the write-ack cycle.
- Wishbone handshake:
  - wbs_ack_o rises the cycle after cyc&stb&!ack and is high for exactly one cycle. Back-to-back accesses therefore complete every 2 cycles.
  - Read data is registered into wbs_dat_o with ack, and wbs_dat_o is 0 when ack is low.
  - Writes commit on the ack cycle.
- Collisions:
  - clr coincident with an edge: clear wins (counter reads 0 afterwards), but the pending bit still sets.
  - W1C coincident with a new event on the same bit: set wins.
  - Write of en=0 coincident with an edge: the edge is still counted.
- Interrupt: irq_o = registered (rise_pend&rise_ie)|(fall_pend&fall_ie). It asserts 1 cycle after the pend bit sets.

Test Plan:
- Reset then read all 8 offsets -> all read 0; ack high exactly 1 cycle per access, 2-cycle spacing for back-to-back accesses.
- en=1, FILT_LEN=4, comp_in step 0->1 held -> comp_level_o rises 6 cycles after the step; RISE_CNT=1; 3-cycle glitch pulses -> no change.
- Square wave on comp_in, period 100 cycles, 5 rises -> RISE_CNT=5, FALL_CNT=4 or 5, PERIOD=100, per_valid=1 after the 2nd rise only.
- rise_ie=1, one rise -> irq_o=1; W1C STATUS[1] -> irq_o=0 next cycle; W1C in the same cycle as a new rise -> pend stays 1.
- CNT_W=8, 300 rises -> RISE_CNT saturates at 255; clr write coincident with a rise -> RISE_CNT=0, rise_pend=1.
- Pulse wb_rst_ni low during an active read and mid-filter count -> ack dropped, all registers back to 0, and no spurious edge when en is re-enabled with comp_in high.

Source files
------------

// File: rtl/comp_edge_capture.sv
// comp_edge_capture: filtered comparator edge counter / period meter with Wishbone registers and IRQ
module comp_edge_capture #(
    parameter int FILT_LEN = 4,
    parameter int CNT_W    = 16,
    parameter int PER_W    = 24
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        comp_in,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o,
    output logic        comp_level_o
);
    logic s1, s2, en, en_d, rise_ie, fall_ie, rise_pend, fall_pend, armed, per_valid;
    logic [3:0] fcnt;
    logic [CNT_W-1:0] rise_cnt, fall_cnt;
    logic [PER_W-1:0] per_cnt, period;
    logic [2:0] adr;
    logic [31:0] rdata;
    logic req, wr, clr, w1c_rise, w1c_fall, active, en_rise, hit, rise_ev, fall_ev;
    logic unused;

    assign unused = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i[31:4]};

    always_comb begin
        adr      = wbs_adr_i[4:2];
        req      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
        // every register field lives in byte lane 0
        wr       = wbs_ack_o & wbs_cyc_i & wbs_stb_i & wbs_we_i & wbs_sel_i[0];
        clr      = wr && adr == 3'd0 && wbs_dat_i[3];
        w1c_rise = wr && adr == 3'd1 && wbs_dat_i[1];
        w1c_fall = wr && adr == 3'd1 && wbs_dat_i[2];
        active   = en & en_d;
        en_rise  = en & ~en_d;
        hit      = active && (s2 != comp_level_o) && fcnt == 4'(FILT_LEN - 1);
        rise_ev  = hit & s2;
        fall_ev  = hit & ~s2;
        rdata    = adr == 3'd0 ? {29'd0, fall_ie, rise_ie, en} :
                   adr == 3'd1 ? {27'd0, per_valid, armed, fall_pend, rise_pend, comp_level_o} :
                   adr == 3'd2 ? 32'(rise_cnt) :
                   adr == 3'd3 ? 32'(fall_cnt) :
                   adr == 3'd4 ? 32'(period) : 32'd0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            {s1, s2, en, en_d, rise_ie, fall_ie, rise_pend, fall_pend, armed, per_valid} <= '0;
            fcnt         <= '0;
            rise_cnt     <= '0;
            fall_cnt     <= '0;
            per_cnt      <= '0;
            period       <= '0;
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= '0;
            irq_o        <= 1'b0;
            comp_level_o <= 1'b0;
        end else begin
            s1        <= comp_in;
            s2        <= s1;
            en_d      <= en;
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : 32'd0;
            irq_o     <= (rise_pend & rise_ie) | (fall_pend & fall_ie);
            if (wr && adr == 3'd0)
                {fall_ie, rise_ie, en} <= wbs_dat_i[2:0];
            // enabling adopts the current level silently so no edge is fabricated
            if (en_rise) begin
                comp_level_o <= s2;
                fcnt         <= '0;
            end else if (active) begin
                if (s2 == comp_level_o || hit)
                    fcnt <= '0;
                else
                    fcnt <= fcnt + 4'd1;
                if (hit)
                    comp_level_o <= s2;
            end
            rise_pend <= rise_ev | (rise_pend & ~w1c_rise);
            fall_pend <= fall_ev | (fall_pend & ~w1c_fall);
            if (clr)
                rise_cnt <= '0;
            else if (rise_ev && !(&rise_cnt))
                rise_cnt <= rise_cnt + CNT_W'(1);
            if (clr)
                fall_cnt <= '0;
            else if (fall_ev && !(&fall_cnt))
                fall_cnt <= fall_cnt + CNT_W'(1);
            if (clr) begin
                per_cnt   <= '0;
                armed     <= 1'b0;
                per_valid <= 1'b0;
                period    <= '0;
            end else if (en_rise) begin
                per_cnt <= '0;
                armed   <= 1'b0;
            end else if (rise_ev) begin
                per_cnt <= PER_W'(1);
                armed   <= 1'b1;
                if (armed) begin
                    period    <= per_cnt;
                    per_valid <= 1'b1;
                end
            end else if (armed && active && !(&per_cnt)) begin
                per_cnt <= per_cnt + PER_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_comp_edge_capture.sv
// tb_comp_edge_capture: directed self-checking bench for comp_edge_capture
module tb_comp_edge_capture;
    logic        clk = 1'b0;
    logic        rst_n, comp_in, cyc, stb, we, ack, irq, level;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w, dat_r, q;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    comp_edge_capture #(.FILT_LEN(4), .CNT_W(8), .PER_W(24)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .comp_in(comp_in),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
        .irq_o(irq), .comp_level_o(level)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // classic handshake: hold the request until ack has been seen at a clock edge
    task automatic wb(input logic w, input logic [2:0] a, input logic [31:0] d, output logic [31:0] r);
        logic got;
        got = 1'b0;
        r = '0;
        cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hf; adr = {27'd0, a, 2'b00}; dat_w = d;
        for (int i = 0; i < 8 && !got; i++) begin
            tick(1);
            if (ack) begin
                got = 1'b1;
                r = dat_r;
            end
        end
        check("ack_seen", 32'(got), 32'd1);
        tick(1);
        check("ack_one_cycle", 32'(ack), 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; comp_in = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = '0; dat_w = '0;
        tick(3);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", dat_r, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        rst_n = 1'b1;
        tick(1);

        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hf;
        for (int i = 0; i < 8; i++) begin
            adr = 32'(i) << 2;
            tick(1);
            check("b2b_ack_hi", 32'(ack), 32'd1);
            check("b2b_dat", dat_r, 32'd0);
            tick(1);
            check("b2b_ack_lo", 32'(ack), 32'd0);
        end
        cyc = 1'b0; stb = 1'b0;

        wb(1'b1, 3'd0, 32'h1, q);
        tick(3);
        comp_in = 1'b1;
        tick(5);
        check("step_lat5", 32'(level), 32'd0);
        tick(1);
        check("step_lat6", 32'(level), 32'd1);
        wb(1'b0, 3'd2, 32'd0, q);
        check("step_rise_cnt", q, 32'd1);
        comp_in = 1'b0;
        tick(3);
        comp_in = 1'b1;
        tick(10);
        check("glitch_level", 32'(level), 32'd1);
        wb(1'b0, 3'd3, 32'd0, q);
        check("glitch_fall_cnt", q, 32'd0);

        comp_in = 1'b0;
        tick(10);
        wb(1'b1, 3'd0, 32'h9, q);
        wb(1'b0, 3'd0, 32'd0, q);
        check("ctrl_clr_reads0", q, 32'h1);
        for (int i = 0; i < 5; i++) begin
            comp_in = 1'b1;
            tick(50);
            comp_in = 1'b0;
            tick(50);
            if (i == 0) begin
                wb(1'b0, 3'd1, 32'd0, q);
                check("sq_armed_not_valid", 32'(q[4:3]), 32'd1);
            end
        end
        wb(1'b0, 3'd2, 32'd0, q);
        check("sq_rise_cnt", q, 32'd5);
        wb(1'b0, 3'd3, 32'd0, q);
        check("sq_fall_cnt", q, 32'd5);
        wb(1'b0, 3'd4, 32'd0, q);
        check("sq_period", q, 32'd100);
        wb(1'b0, 3'd1, 32'd0, q);
        check("sq_per_valid", 32'(q[4]), 32'd1);

        wb(1'b1, 3'd1, 32'h6, q);
        wb(1'b1, 3'd0, 32'h3, q);
        check("irq_idle", 32'(irq), 32'd0);
        comp_in = 1'b1;
        tick(6);
        check("irq_pend_cycle", 32'(irq), 32'd0);
        tick(1);
        check("irq_set", 32'(irq), 32'd1);
        wb(1'b1, 3'd1, 32'h2, q);
        tick(1);
        check("irq_w1c", 32'(irq), 32'd0);
        wb(1'b0, 3'd1, 32'd0, q);
        check("w1c_pend_clear", 32'(q[1]), 32'd0);
        comp_in = 1'b0;
        tick(20);
        comp_in = 1'b1;
        tick(4);
        wb(1'b1, 3'd1, 32'h2, q);
        wb(1'b0, 3'd1, 32'd0, q);
        check("w1c_collide_set_wins", 32'(q[1]), 32'd1);

        wb(1'b1, 3'd0, 32'h9, q);
        comp_in = 1'b0;
        tick(10);
        for (int i = 0; i < 300; i++) begin
            comp_in = 1'b1;
            tick(6);
            comp_in = 1'b0;
            tick(6);
        end
        tick(4);
        wb(1'b0, 3'd2, 32'd0, q);
        check("sat_rise_cnt", q, 32'd255);
        wb(1'b0, 3'd3, 32'd0, q);
        check("sat_fall_cnt", q, 32'd255);
        wb(1'b1, 3'd1, 32'h6, q);
        comp_in = 1'b1;
        tick(4);
        wb(1'b1, 3'd0, 32'h9, q);
        wb(1'b0, 3'd2, 32'd0, q);
        check("clr_collide_cnt", q, 32'd0);
        wb(1'b0, 3'd3, 32'd0, q);
        check("clr_fall_cnt", q, 32'd0);
        wb(1'b0, 3'd1, 32'd0, q);
        check("clr_collide_pend", 32'(q[1]), 32'd1);

        comp_in = 1'b0;
        tick(3);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'd2 << 2;
        tick(1);
        check("mid_read_ack", 32'(ack), 32'd1);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_ack", 32'(ack), 32'd0);
        check("mid_rst_dat", dat_r, 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_irq", 32'(irq), 32'd0);
        tick(1);
        cyc = 1'b0; stb = 1'b0;
        rst_n = 1'b1;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            wb(1'b0, 3'(i), 32'd0, q);
            check("post_rst_reg", q, 32'd0);
        end
        comp_in = 1'b1;
        tick(5);
        wb(1'b1, 3'd0, 32'h1, q);
        tick(3);
        check("reen_level", 32'(level), 32'd1);
        wb(1'b0, 3'd1, 32'd0, q);
        check("reen_status", q, 32'h1);
        wb(1'b0, 3'd2, 32'd0, q);
        check("reen_rise_cnt", q, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
